regfile_sb: RTL and testbench

- Parametrised, clocked successor to the CPU's combinational register file.
- Two asynchronous read ports and one synchronous write-back port.
- Hardwired-zero register 0.
- Per-register busy scoreboard: decode marks a destination pending at issue; write-back clears the mark. Decode uses the busy flags to detect RAW hazards.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/regfile_sb_scoreboard.sv | 67 ++++++
 rtl/regfile_sb.sv | 100 ++++++++++
 tb/tb_regfile_sb.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU register-file types and defaults used by regfile_sb and its scoreboard.
package cpu_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  typedef logic [DEF_DATA_W-1:0] reg_data_t;
  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

  // Architectural zero register index.
  localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy scoreboard: issue marks a destination pending, write-back clears it.
// pend_cnt is the registered popcount of the busy vector.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_addr,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      wa,
  output logic [(2**ADDR_W)-1:0] busy,
  output logic [ADDR_W:0]        pend_cnt
);

  localparam int unsigned NREG  = 2**ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam bit          ZERO_ON = (ZERO_REG != 0);

  logic [NREG-1:0]  set_v;
  logic [NREG-1:0]  clr_v;
  logic [NREG-1:0]  busy_d;
  logic [NREG-1:0]  busy_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Address decode of the issue and write-back strobes.
  always_comb begin
    set_v = '0;
    clr_v = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      set_v[r] = iss_en && (iss_addr == ADDR_W'(r)) && !(ZERO_ON && (r == 0));
      clr_v[r] = we && (wa == ADDR_W'(r));
    end
  end

  // Set beats clear: a same-cycle issue is a newer producer than the retiring one.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      if (set_v[r]) begin
        busy_d[r] = 1'b1;
      end else if (clr_v[r]) begin
        busy_d[r] = 1'b0;
      end
      cnt_d = cnt_d + CNT_W'(busy_d[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign pend_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with two async read ports, one sync write port and a busy scoreboard.
// Define REGFILE_SB_BYPASS_EN for same-cycle write-through forwarding on reads.
module regfile_sb
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int unsigned NREG    = 2**ADDR_W;
  localparam bit          ZERO_ON = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];
  logic [NREG-1:0]   busy_vec;
  logic              wr_en;

  assign wr_en = we && !(ZERO_ON && (wa == ZADDR));

  always_comb begin
    rf_d = rf_q;
    if (wr_en) begin
      rf_d[wa] = wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        rf_q[r] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .we       (we),
    .wa       (wa),
    .busy     (busy_vec),
    .pend_cnt (pend_cnt)
  );

  // Read port 1; the zero register masks storage and busy.
  always_comb begin
    rd1   = rf_q[ra1];
    busy1 = busy_vec[ra1];
    if (ZERO_ON && (ra1 == ZADDR)) begin
      rd1   = '0;
      busy1 = 1'b0;
    end
`ifdef REGFILE_SB_BYPASS_EN
    if (wr_en && !rst && (ra1 == wa)) begin
      rd1   = wd;
      busy1 = 1'b0;
    end
`endif
  end

  // Read port 2 mirrors port 1.
  always_comb begin
    rd2   = rf_q[ra2];
    busy2 = busy_vec[ra2];
    if (ZERO_ON && (ra2 == ZADDR)) begin
      rd2   = '0;
      busy2 = 1'b0;
    end
`ifdef REGFILE_SB_BYPASS_EN
    if (wr_en && !rst && (ra2 == wa)) begin
      rd2   = wd;
      busy2 = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboarded random + directed bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic [4:0]  ra1, ra2, iss_addr, wa;
  logic [31:0] rd1, rd2, wd;
  logic        busy1, busy2, iss_en, we;
  logic [5:0]  pend_cnt;

  regfile_sb dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .iss_en(iss_en), .iss_addr(iss_addr),
    .we(we), .wa(wa), .wd(wd), .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        b1;
    logic        b2;
    logic [5:0]  pc;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: architectural state after every edge seen so far.
  logic [31:0] m_rf   [32];
  bit          m_busy [32];

  function automatic int m_pend();
    int n = 0;
    for (int i = 0; i < 32; i++) n += m_busy[i] ? 1 : 0;
    return n;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] v = (a == 0) ? 32'h0 : m_rf[a];
`ifdef REGFILE_SB_BYPASS_EN
    if (we && !rst && a == wa && a != 0) v = wd;
`endif
    return v;
  endfunction

  function automatic logic m_busy_rd(input logic [4:0] a);
    logic b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_SB_BYPASS_EN
    if (we && !rst && a == wa && a != 0) b = 1'b0;
`endif
    return b;
  endfunction

  task automatic cyc(input string tag, input bit r, input bit w, input logic [4:0] a,
                     input logic [31:0] d, input bit ie, input logic [4:0] ia,
                     input logic [4:0] r1, input logic [4:0] r2);
    exp_t e;
    @(negedge clk);
    rst = r; we = w; wa = a; wd = d; iss_en = ie; iss_addr = ia; ra1 = r1; ra2 = r2;
    e.rd1 = m_read(r1);
    e.rd2 = m_read(r2);
    e.b1  = m_busy_rd(r1);
    e.b2  = m_busy_rd(r2);
    e.pc  = 6'(m_pend());
    e.tag = tag;
    exp_q.push_back(e);
    // Advance the model across the coming edge.
    if (r) begin
      for (int i = 0; i < 32; i++) begin m_rf[i] = 0; m_busy[i] = 0; end
    end else begin
      if (w && a != 0) m_rf[a] = d;
      if (w) m_busy[a] = 0;
      if (ie && ia != 0) m_busy[ia] = 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-low-phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk({e.tag, ".rd1"},   rd1, e.rd1);
        chk({e.tag, ".rd2"},   rd2, e.rd2);
        chk({e.tag, ".busy1"}, 32'(busy1), 32'(e.b1));
        chk({e.tag, ".busy2"}, 32'(busy2), 32'(e.b2));
        chk({e.tag, ".pend"},  32'(pend_cnt), 32'(e.pc));
      end
    end
  end

  initial begin
    logic [4:0] a, r1, r2;
    for (int i = 0; i < 32; i++) begin m_rf[i] = 0; m_busy[i] = 0; end
    rst = 1; we = 0; wa = 0; wd = 0; iss_en = 0; iss_addr = 0; ra1 = 0; ra2 = 0;
    @(posedge clk);
    @(posedge clk);

    // Reset: preload, then reset with a concurrent write and issue.
    cyc("rst_init", 0, 0, 0, 0, 0, 0, 3, 4);
    cyc("pre_w3",   0, 1, 3, 32'h1111, 1, 3, 3, 4);
    cyc("pre_w4",   0, 1, 4, 32'h2222, 1, 6, 3, 4);
    cyc("pre_rd",   0, 0, 0, 0, 0, 0, 3, 6);
    cyc("rst_cyc",  1, 1, 3, 32'hDEAD, 1, 8, 3, 4);
    cyc("post_rst", 0, 0, 0, 0, 0, 0, 3, 4);
    cyc("post_rst2",0, 0, 0, 0, 0, 0, 6, 8);

    // Zero register ignores writes and issues.
    cyc("z_wr",  0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
    cyc("z_rd",  0, 0, 0, 0, 1, 0, 0, 0);
    cyc("z_iss", 0, 0, 0, 0, 0, 0, 0, 1);

    // Basic write, with a read-during-write on port 2.
    cyc("w5",    0, 1, 5, 32'h12345678, 0, 0, 0, 5);
    cyc("r5",    0, 0, 0, 0, 0, 0, 5, 5);

    // Scoreboard set and clear.
    cyc("iss7",  0, 0, 0, 0, 1, 7, 7, 9);
    cyc("iss9",  0, 0, 0, 0, 1, 9, 7, 9);
    cyc("wb7",   0, 1, 7, 32'hA5, 0, 0, 7, 9);
    cyc("aft7",  0, 0, 0, 0, 0, 0, 7, 9);

    // Simultaneous set/clear on the same register.
    cyc("iss7b", 0, 0, 0, 0, 1, 7, 7, 9);
    cyc("sc7",   0, 1, 7, 32'h55, 1, 7, 7, 9);
    cyc("aftsc", 0, 0, 0, 0, 0, 0, 7, 9);
    cyc("clr9",  0, 1, 9, 32'h99, 0, 0, 7, 9);
    cyc("clr7",  0, 1, 7, 32'h77, 0, 0, 7, 9);

    // Saturation: every non-zero register busy, re-issue, then drain.
    for (int i = 1; i < 32; i++) cyc("sat_iss", 0, 0, 0, 0, 1, 5'(i), 5'(i), 1);
    cyc("sat_re1", 0, 0, 0, 0, 1, 1, 1, 31);
    cyc("sat_chk", 0, 0, 0, 0, 0, 0, 1, 31);
    for (int i = 1; i < 32; i++) cyc("drain", 0, 1, 5'(i), 32'(i * 3), 0, 0, 5'(i), 31);
    cyc("drained", 0, 1, 0, 0, 1, 0, 1, 0);
    cyc("idle_wb", 0, 1, 12, 32'hC0FFEE, 0, 0, 12, 13);

    // Random traffic with occasional reset.
    for (int n = 0; n < 1500; n++) begin
      a  = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31));
      cyc("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), a, $urandom(),
          ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 31)), r1, r2);
    end

    @(negedge clk);
    rst = 0; we = 0; iss_en = 0;
    repeat (3) @(negedge clk);
    #4;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
